// File: rtl/fe_pred_stage.sv
// Fetch stage: PC register, FE latch toward DE, optional gshare direction predictor plus tagged BTB.
// Define FE_PRED_EN to build the predictor; without it fetch is strictly sequential (PC+4).
module fe_pred_stage #(
    parameter int               DBITS        = 32,
    parameter int               INSTBITS     = 32,
    parameter logic [DBITS-1:0] STARTPC      = 32'h200,
    parameter int               PTINDEXBITS  = 8,
    parameter int               BTBINDEXBITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [DBITS-1:0]       imem_addr,
    input  logic [INSTBITS-1:0]    imem_rdata,
    input  logic                   stall_DE,
    input  logic                   br_redirect,
    input  logic [DBITS-1:0]       br_target,
    input  logic                   upd_valid,
    input  logic                   upd_taken,
    input  logic [DBITS-1:0]       upd_pc,
    input  logic [DBITS-1:0]       upd_target,
    input  logic [PTINDEXBITS-1:0] upd_pt_idx,
    output logic                   fe_valid,
    output logic [INSTBITS-1:0]    fe_inst,
    output logic [DBITS-1:0]       fe_pc,
    output logic [DBITS-1:0]       fe_pcplus,
    output logic [DBITS-1:0]       fe_inst_count,
    output logic                   pred_btb_hit,
    output logic                   pred_taken,
    output logic [DBITS-1:0]       pred_target,
    output logic [PTINDEXBITS-1:0] pred_pt_idx
);

    localparam int TAGBITS    = DBITS - BTBINDEXBITS - 2;
    localparam int PTENTRIES  = 1 << PTINDEXBITS;
    localparam int BTBENTRIES = 1 << BTBINDEXBITS;

    typedef struct packed {
        logic                   valid;
        logic [INSTBITS-1:0]    inst;
        logic [DBITS-1:0]       pc;
        logic [DBITS-1:0]       pcplus;
        logic [DBITS-1:0]       count;
        logic                   btb_hit;
        logic                   taken;
        logic [DBITS-1:0]       target;
        logic [PTINDEXBITS-1:0] pt_idx;
    } fe_latch_t;

    fe_latch_t              latch;
    logic [DBITS-1:0]       pc;
    logic [DBITS-1:0]       pc_plus;
    logic [DBITS-1:0]       fetch_count;
    logic                   lookup_hit;
    logic                   lookup_taken;
    logic [DBITS-1:0]       lookup_target;
    logic [PTINDEXBITS-1:0] lookup_pt_idx;

    assign imem_addr = pc;
    assign pc_plus   = pc + DBITS'(4);

`ifdef FE_PRED_EN
    logic [PTINDEXBITS-1:0]  bhr;
    logic [1:0]              pt         [PTENTRIES];
    logic [BTBENTRIES-1:0]   btb_valid;
    logic [TAGBITS-1:0]      btb_tag    [BTBENTRIES];
    logic [DBITS-1:0]        btb_target [BTBENTRIES];
    logic [BTBINDEXBITS-1:0] btb_idx;
    logic [BTBINDEXBITS-1:0] upd_btb_idx;
    logic                    unused_upd_pc_lo;

    assign btb_idx          = pc[BTBINDEXBITS+1:2];
    assign upd_btb_idx      = upd_pc[BTBINDEXBITS+1:2];
    assign lookup_pt_idx    = pc[PTINDEXBITS+1:2] ^ bhr;
    assign lookup_hit       = btb_valid[btb_idx] && (btb_tag[btb_idx] == pc[DBITS-1:BTBINDEXBITS+2]);
    assign lookup_taken     = lookup_hit && pt[lookup_pt_idx][1];
    assign lookup_target    = lookup_taken ? btb_target[btb_idx] : pc_plus;
    assign unused_upd_pc_lo = ^upd_pc[1:0];

    // Training writes land at the edge, so a same-cycle lookup always sees the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            bhr       <= '0;
            btb_valid <= '0;
            for (int i = 0; i < PTENTRIES; i++) pt[i] <= 2'b01;
        end else if (upd_valid) begin
            bhr <= {bhr[PTINDEXBITS-2:0], upd_taken};
            if (upd_taken && pt[upd_pt_idx] != 2'b11)
                pt[upd_pt_idx] <= pt[upd_pt_idx] + 2'b01;
            else if (!upd_taken && pt[upd_pt_idx] != 2'b00)
                pt[upd_pt_idx] <= pt[upd_pt_idx] - 2'b01;
            if (upd_taken) btb_valid[upd_btb_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target arrays carry no reset; btb_valid alone qualifies them, which keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && upd_valid && upd_taken) begin
            btb_tag[upd_btb_idx]    <= upd_pc[DBITS-1:BTBINDEXBITS+2];
            btb_target[upd_btb_idx] <= upd_target;
        end
    end
`else
    logic unused_upd;

    assign lookup_pt_idx = '0;
    assign lookup_hit    = 1'b0;
    assign lookup_taken  = 1'b0;
    assign lookup_target = pc_plus;
    assign unused_upd    = ^{upd_valid, upd_taken, upd_pc, upd_target, upd_pt_idx};
`endif

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= STARTPC;
            fetch_count <= '0;
            latch       <= '0;
        end else if (br_redirect) begin
            pc    <= br_target;
            latch <= '0;
        end else if (!stall_DE) begin
            pc           <= lookup_target;
            fetch_count  <= fetch_count + DBITS'(1);
            latch.valid   <= 1'b1;
            latch.inst    <= imem_rdata;
            latch.pc      <= pc;
            latch.pcplus  <= pc_plus;
            latch.count   <= fetch_count;
            latch.btb_hit <= lookup_hit;
            latch.taken   <= lookup_taken;
            latch.target  <= lookup_target;
            latch.pt_idx  <= lookup_pt_idx;
        end
    end

    assign fe_valid      = latch.valid;
    assign fe_inst       = latch.inst;
    assign fe_pc         = latch.pc;
    assign fe_pcplus     = latch.pcplus;
    assign fe_inst_count = latch.count;
    assign pred_btb_hit  = latch.btb_hit;
    assign pred_taken    = latch.taken;
    assign pred_target   = latch.target;
    assign pred_pt_idx   = latch.pt_idx;

endmodule

// File: tb/tb_fe_pred_stage.sv
// Scoreboard bench for fe_pred_stage: the driver queues the expected FE latch per cycle, a monitor checks it.
// Expectations follow the FE_PRED_EN setting of the build.
module tb_fe_pred_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_DE = 1'b0;
    logic        br_redirect = 1'b0;
    logic [31:0] br_target = '0;
    logic        upd_valid = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic [7:0]  upd_pt_idx = '0;
    logic        fe_valid;
    logic [31:0] fe_inst;
    logic [31:0] fe_pc;
    logic [31:0] fe_pcplus;
    logic [31:0] fe_inst_count;
    logic        pred_btb_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_pt_idx;

    fe_pred_stage dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall_DE(stall_DE), .br_redirect(br_redirect), .br_target(br_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_pt_idx(upd_pt_idx),
        .fe_valid(fe_valid), .fe_inst(fe_inst), .fe_pc(fe_pc), .fe_pcplus(fe_pcplus),
        .fe_inst_count(fe_inst_count), .pred_btb_hit(pred_btb_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_pt_idx(pred_pt_idx)
    );

    always #5 clk = ~clk;

    // Instruction memory: 0x13 at 0x200, distinct word elsewhere.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h13 ^ ((a - 32'h200) << 10);
    endfunction
    assign imem_rdata = inst_of(imem_addr);

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcplus;
        logic [31:0] cnt;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [7:0]  ptidx;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc  = 32'h200;
    logic [31:0] m_cnt = '0;
    logic [7:0]  m_bhr = '0;
    logic        nu_valid = 1'b0;
    logic        nu_taken = 1'b0;
    logic [31:0] nu_pc = '0;
    logic [31:0] nu_tgt = '0;
    logic [7:0]  nu_idx = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_upd(input logic taken, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [7:0] idx);
        nu_valid = 1'b1;
        nu_taken = taken;
        nu_pc    = pc;
        nu_tgt   = tgt;
        nu_idx   = idx;
    endtask

    // One clock: drive inputs, queue the latch contents expected after the coming edge.
    // p_hit/p_taken/p_tgt are the hand-derived predictions for the PC fetched this cycle.
    task automatic step(input logic rst, input logic redir, input logic [31:0] tgt, input logic stall,
                        input logic p_hit, input logic p_taken, input logic [31:0] p_tgt);
        exp_t        e;
        logic        h;
        logic        t;
        logic [31:0] nxt;
        @(negedge clk);
        #1;
        reset       = rst;
        br_redirect = redir;
        br_target   = tgt;
        stall_DE    = stall;
        upd_valid   = nu_valid;
        upd_taken   = nu_taken;
        upd_pc      = nu_pc;
        upd_target  = nu_tgt;
        upd_pt_idx  = nu_idx;
        h = p_hit;
        t = p_taken;
`ifndef FE_PRED_EN
        h = 1'b0;
        t = 1'b0;
`endif
        e = '{default: '0};
        if (rst) begin
            m_pc  = 32'h200;
            m_cnt = '0;
            m_bhr = '0;
        end else if (redir) begin
            m_pc = tgt;
        end else if (stall) begin
            e = last_e;
        end else begin
            nxt      = t ? p_tgt : m_pc + 32'd4;
            e.valid  = 1'b1;
            e.inst   = inst_of(m_pc);
            e.pc     = m_pc;
            e.pcplus = m_pc + 32'd4;
            e.cnt    = m_cnt;
            e.hit    = h;
            e.taken  = t;
            e.tgt    = nxt;
`ifdef FE_PRED_EN
            e.ptidx  = m_pc[9:2] ^ m_bhr;
`endif
            m_pc  = nxt;
            m_cnt = m_cnt + 32'd1;
        end
        if (!rst && nu_valid) m_bhr = {m_bhr[6:0], nu_taken};
        e.addr   = m_pc;
        last_e   = e;
        nu_valid = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic go();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic go_pred(input logic hit, input logic taken, input logic [31:0] tgt);
        step(1'b0, 1'b0, '0, 1'b0, hit, taken, tgt);
    endtask

    // Monitor: each negedge the DUT presents the state produced by the edge just passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("fe_valid",      64'(fe_valid),      64'(e.valid));
                check("imem_addr",     64'(imem_addr),     64'(e.addr));
                check("fe_inst",       64'(fe_inst),       64'(e.inst));
                check("fe_pc",         64'(fe_pc),         64'(e.pc));
                check("fe_pcplus",     64'(fe_pcplus),     64'(e.pcplus));
                check("fe_inst_count", 64'(fe_inst_count), 64'(e.cnt));
                check("pred_btb_hit",  64'(pred_btb_hit),  64'(e.hit));
                check("pred_taken",    64'(pred_taken),    64'(e.taken));
                check("pred_target",   64'(pred_target),   64'(e.tgt));
                check("pred_pt_idx",   64'(pred_pt_idx),   64'(e.ptidx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        go();                                            // 0x200, count 0
        go();                                            // 0x204, count 1
        repeat (3) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);  // frozen at 0x208
        go();                                            // 0x208, count 2
        step(1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, '0); // redirect wins over stall
        go();                                            // 0x400, count 3

        // Train BTB[4]/PT[0x87] taken twice; second update arrives during a stall.
        set_upd(1'b1, 32'h210, 32'h300, 8'h87);
        step(1'b0, 1'b1, 32'h210, 1'b0, 1'b0, 1'b0, '0);
        set_upd(1'b1, 32'h210, 32'h300, 8'h87);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        // Fetch of 0x210 (pt_idx 0x84^0x03=0x87) predicts taken; same-cycle not-taken update must not affect it.
        set_upd(1'b0, 32'h250, 32'h500, 8'h87);
        go_pred(1'b1, 1'b1, 32'h300);
        go();                                            // fetch at predicted 0x300

        // Four not-taken updates to PT[0xE4] (0x84 ^ BHR 0x60 after they shift in); BTB must stay intact.
        repeat (3) begin
            set_upd(1'b0, 32'h250, 32'h500, 8'hE4);
            go();
        end
        set_upd(1'b0, 32'h250, 32'h500, 8'hE4);
        step(1'b0, 1'b1, 32'h210, 1'b0, 1'b0, 1'b0, '0);
        go_pred(1'b1, 1'b0, '0);                         // hit, counter 0 -> sequential
        go();

        // PC wraps past the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, '0);
        go();
        go();

        // Reset mid-run clears BTB, BHR and count.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (5) go();

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
